// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: captures execute results, holds them across memory
// stalls, turns flushed/invalid slots into bubbles and freezes after HALT retires.
module ex_mem_pipe #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_write_data,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_halt,
   input  logic              ex_reg_write,
   input  logic [REG_W-1:0]  ex_write_reg,
   input  logic              flush,
   input  logic              mem_stall,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_halt,
   output logic              mem_reg_write,
   output logic [REG_W-1:0]  mem_write_reg,
   output logic              mem_valid,
   output logic              ex_stall,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_WAIT   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_write_data;
   logic              r_read;
   logic              r_write;
   logic              r_halt;
   logic              r_reg_write;
   logic [REG_W-1:0]  r_write_reg;
   logic              r_valid;
   logic [CNT_W-1:0]  r_stall_cycles;

   logic w_frozen;
   logic w_capture;
   logic w_retire_halt;
   logic w_load;

   assign w_frozen      = (r_state == S_HALTED);
   assign w_capture     = !w_frozen && !mem_stall;
   // A valid HALT sitting in the slot retires on the first unstalled edge instead of capturing.
   assign w_retire_halt = w_capture && r_valid && r_halt;
   assign w_load        = ex_valid && !flush;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:    if (mem_stall) w_state_nxt = S_WAIT;
                   else if (w_retire_halt) w_state_nxt = S_HALTED;
         S_WAIT:   if (!mem_stall) w_state_nxt = w_retire_halt ? S_HALTED : S_RUN;
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr       <= '0;
         r_write_data <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_halt       <= 1'b0;
         r_reg_write  <= 1'b0;
         r_write_reg  <= '0;
         r_valid      <= 1'b0;
      end else if (w_retire_halt) begin
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_reg_write <= 1'b0;
         r_valid     <= 1'b0;
      end else if (w_capture) begin
         if (w_load) begin
            r_addr       <= ex_alu_result;
            r_write_data <= ex_write_data;
            r_read       <= ex_mem_read;
            r_write      <= ex_mem_write;
            r_halt       <= ex_halt;
            r_reg_write  <= ex_reg_write;
            r_write_reg  <= ex_write_reg;
            r_valid      <= 1'b1;
         end else begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_halt      <= 1'b0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (mem_stall && !w_frozen && (r_stall_cycles != {CNT_W{1'b1}})) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign mem_addr       = r_addr;
   assign mem_write_data = r_write_data;
   assign mem_read       = r_read;
   assign mem_write      = r_write;
   assign mem_halt       = r_halt;
   assign mem_reg_write  = r_reg_write;
   assign mem_write_reg  = r_write_reg;
   assign mem_valid      = r_valid;
   assign halted         = w_frozen;
   assign ex_stall       = mem_stall || w_frozen;
   assign stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: a reference model pushes the expected MEM
// slot per edge into a scoreboard queue, popped and compared after each edge.
module tb_ex_mem_pipe;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;
   localparam int CNT_W  = 4;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              read;
      logic              write;
      logic              halt;
      logic              regw;
      logic [REG_W-1:0]  wreg;
      logic              valid;
      logic              halted;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] ex_write_data;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_halt;
   logic              ex_reg_write;
   logic [REG_W-1:0]  ex_write_reg;
   logic              flush;
   logic              mem_stall;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic              mem_halt;
   logic              mem_reg_write;
   logic [REG_W-1:0]  mem_write_reg;
   logic              mem_valid;
   logic              ex_stall;
   logic              halted;
   logic [CNT_W-1:0]  stall_cycles;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t m;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ex_mem_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
      .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
      .flush(flush), .mem_stall(mem_stall),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_halt(mem_halt),
      .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
      .mem_valid(mem_valid), .ex_stall(ex_stall), .halted(halted),
      .stall_cycles(stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic compare(input exp_t e);
      check("addr",   32'(mem_addr),       32'(e.addr));
      check("wdata",  32'(mem_write_data), 32'(e.wdata));
      check("read",   32'(mem_read),       32'(e.read));
      check("write",  32'(mem_write),      32'(e.write));
      check("halt",   32'(mem_halt),       32'(e.halt));
      check("regw",   32'(mem_reg_write),  32'(e.regw));
      check("wreg",   32'(mem_write_reg),  32'(e.wreg));
      check("valid",  32'(mem_valid),      32'(e.valid));
      check("halted", 32'(halted),         32'(e.halted));
      check("cnt",    32'(stall_cycles),   32'(e.cnt));
      check("ex_stall", 32'(ex_stall),     32'(mem_stall || e.halted));
   endtask

   // Expected slot after the coming edge, derived from the behaviour description.
   task automatic step();
      exp_t n;
      n = m;
      if (!m.halted) begin
         if (mem_stall) begin
            if (m.cnt != 4'hF) n.cnt = m.cnt + 1'b1;
         end else if (m.valid && m.halt) begin
            n.halted = 1'b1;
            n.read   = 1'b0;
            n.write  = 1'b0;
            n.regw   = 1'b0;
            n.valid  = 1'b0;
         end else if (ex_valid && !flush) begin
            n.addr  = ex_alu_result;
            n.wdata = ex_write_data;
            n.read  = ex_mem_read;
            n.write = ex_mem_write;
            n.halt  = ex_halt;
            n.regw  = ex_reg_write;
            n.wreg  = ex_write_reg;
            n.valid = 1'b1;
         end else begin
            n.read  = 1'b0;
            n.write = 1'b0;
            n.halt  = 1'b0;
            n.regw  = 1'b0;
            n.valid = 1'b0;
         end
      end
      sb_q.push_back(n);
      m = n;
      @(posedge clk);
      @(negedge clk);
      compare(sb_q.pop_front());
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                        input logic rd, input logic wr, input logic h, input logic rw,
                        input logic [2:0] r, input logic f, input logic s);
      ex_valid = v;  ex_alu_result = a; ex_write_data = d;
      ex_mem_read = rd; ex_mem_write = wr; ex_halt = h;
      ex_reg_write = rw; ex_write_reg = r; flush = f; mem_stall = s;
   endtask

   // Asserts reset away from any edge and checks the outputs clear without a clock.
   task automatic apply_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      check({tag, "_valid"},  32'(mem_valid), 32'd0);
      check({tag, "_out"},    32'({mem_addr, mem_write_data, mem_read, mem_write, mem_halt,
                                   mem_reg_write, mem_write_reg}), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_cnt"},    32'(stall_cycles), 32'd0);
      m = '0;
      sb_q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      apply_reset("rst0");
      step();
      check("idle_valid", 32'(mem_valid), 32'd0);

      // Load pass-through
      drive(1'b1, 16'h1234, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
      step();
      check("ld_addr",  32'(mem_addr), 32'h1234);
      check("ld_read",  32'(mem_read), 32'd1);
      check("ld_wreg",  32'(mem_write_reg), 32'd5);
      check("ld_valid", 32'(mem_valid), 32'd1);

      // Store held across a 3-cycle stall while EX keeps changing
      drive(1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h1000 + 16'(i), 16'h5555, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
         step();
         check("st_ex_stall", 32'(ex_stall), 32'd1);
      end
      check("st_hold", 32'({mem_addr, mem_write_data}), 32'h0040BEEF);
      check("st_write", 32'(mem_write), 32'd1);
      check("st_cnt", 32'(stall_cycles), 32'd3);
      drive(1'b1, 16'h2222, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
      step();
      check("rel_addr", 32'(mem_addr), 32'h2222);

      // Flushed store becomes a bubble
      drive(1'b1, 16'h0044, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      step();
      check("fl_bubble", 32'({mem_valid, mem_write}), 32'd0);

      // Flush raised only during a stall does not touch the held store or the release capture
      drive(1'b1, 16'h0050, 16'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0060, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      step();
      step();
      check("fl_hold", 32'({mem_addr, mem_write_data}), 32'h0050CAFE);
      flush = 1'b0;
      mem_stall = 1'b0;
      step();
      check("fl_rel_valid", 32'(mem_valid), 32'd1);
      check("fl_rel_addr", 32'(mem_addr), 32'h0060);

      // Reset mid-stream with a live slot
      apply_reset("rst1");
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step();
      check("rst1_idle", 32'(mem_valid), 32'd0);

      // A flushed HALT never halts
      drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step();
      check("flh_halted", 32'(halted), 32'd0);

      // HALT stalled for 2 cycles, retires on the release edge
      drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
      step();
      step();
      check("h_wait", 32'(halted), 32'd0);
      mem_stall = 1'b0;
      step();
      check("h_halted", 32'({halted, mem_halt}), 32'd3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0200 + 16'(i), 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'(i == 1));
         step();
         check("h_read", 32'(mem_read), 32'd0);
         check("h_ex_stall", 32'(ex_stall), 32'd1);
      end

      // Saturating stall counter
      apply_reset("rst2");
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step();
      check("sat15", 32'(stall_cycles), 32'd15);
      step();
      step();
      check("sat_hold", 32'(stall_cycles), 32'd15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- EX/MEM pipeline register that sits directly upstream of the memory stage and drives its addr, writeData, memRead, memWrite and halt inputs.
- Captures execute-stage results each cycle.
- Holds the captured request stable while the data memory reports a stall, and back-pressures EX.
- Converts flushed or invalid slots into bubbles and freezes the pipe once a halt retires.
- Keeps a saturating count of memory stall cycles.

Parameters:
- DATA_W, 16, datapath width (address, store data, ALU result).
- REG_W, 3, destination register index width.
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_alu_result  in  DATA_W  ALU result; becomes the memory address.
- ex_write_data  in  DATA_W  store data.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_halt  in  1  instruction is HALT.
- ex_reg_write  in  1  instruction writes the register file.
- ex_write_reg  in  REG_W  destination register.
- flush  in  1  squash the EX slot (branch mispredict).
- mem_stall  in  1  stall from the memory stage.
- mem_addr  out  DATA_W  registered address.
- mem_write_data  out  DATA_W  registered store data.
- mem_read  out  1  registered load request.
- mem_write  out  1  registered store request.
- mem_halt  out  1  registered halt; drives the memory dump request.
- mem_reg_write  out  1  registered writeback enable.
- mem_write_reg  out  REG_W  registered destination.
- mem_valid  out  1  MEM slot holds a real instruction.
- ex_stall  out  1  back-pressure to EX/ID/IF.
- halted  out  1  pipe frozen after HALT.
- stall_cycles  out  CNT_W  saturating stall counter.

Behaviour:
- Reset (rst low, asynchronous):
  - All registered outputs go to 0, including stall_cycles and halted.
  - State goes to RUN.
  - Reset mid-stall or mid-HALTED discards the held entry with no residual request.
- States:
  - RUN: a new slot may be captured.
  - WAIT: the held slot is stalled by memory.
  - HALTED: terminal until reset.
- RUN:
  - mem_stall=0: capture on the edge. If ex_valid=1 and flush=0, load all ex_* fields and set mem_valid=1. Otherwise insert a bubble: mem_valid, mem_read, mem_write, mem_halt and mem_reg_write go to 0, and data fields keep their old values.
  - mem_stall=1: hold all outputs and go to WAIT.
- WAIT:
  - Hold every output bit unchanged while mem_stall=1.
  - On the first edge with mem_stall=0, capture exactly as in RUN and return to RUN.
  - No capture occurs in the edge that exits the stall's final stall cycle; capture happens on the edge where mem_stall is sampled 0.
- Flush:
  - Sampled only on capture edges.
  - Upstream keeps flush asserted while ex_stall=1.
  - A held slot is never squashed by flush.
- Halt:
  - When the captured slot has mem_valid=1, mem_halt=1 and mem_stall=0 at an edge, go to HALTED and set halted=1.
  - In HALTED: mem_halt stays 1; mem_read, mem_write, mem_reg_write and mem_valid go to 0; all ex_* and flush inputs are ignored.
  - A flushed HALT never halts.
- ex_stall:
  - Combinational: equals mem_stall in RUN/WAIT.
  - Forced to 1 in HALTED.
  - Never depends on ex_* inputs.
- mem_read and mem_write are both captured as given; mutual exclusion is decoder-enforced and not checked here.
- stall_cycles:
  - Increments by 1 on each edge where mem_stall=1 and state is not HALTED.
  - Saturates at all-ones with no wrap.
  - Never decrements.
- Latency: one cycle from EX inputs to MEM outputs when not stalled.
- Simultaneous events:
  - A stall together with a halted slot keeps WAIT.
  - HALTED is entered only on the unstalled edge.

Test Plan:
- Reset: drive rst=0 mid-stream with outputs non-zero -> all outputs, halted and stall_cycles are 0 immediately without a clock; after release with ex_valid=0, mem_valid stays 0.
- Load pass-through: ex_valid=1, ex_mem_read=1, ex_alu_result=16'h1234, ex_write_reg=3'd5, ex_reg_write=1, mem_stall=0 -> next edge: mem_addr=16'h1234, mem_read=1, mem_write_reg=5, mem_valid=1.
- Stall hold: store captured with mem_addr=16'h0040 and mem_write_data=16'hBEEF; mem_stall=1 for 3 cycles while ex_alu_result changes each cycle -> outputs stay 16'h0040/16'hBEEF/mem_write=1, ex_stall=1, stall_cycles=3; the first edge with mem_stall=0 captures the new EX values.
- Flush: ex_valid=1, ex_mem_write=1, flush=1 -> bubble: mem_valid=0, mem_write=0. Repeat with flush asserted only during a stall and deasserted before the release edge -> the held store is unchanged and the released capture is not squashed.
- Halt: capture ex_halt=1 with mem_stall=1 for 2 cycles -> halted stays 0; on the release edge halted=1 and mem_halt=1; subsequent loads on ex_* produce mem_read=0; ex_stall=1 persists.
- Saturation (CNT_W=4): hold mem_stall=1 for 20 cycles -> stall_cycles reads 15 and remains 15.
